life_cell_serial: RTL and testbench
===================================

Name: life_cell_serial

Overview:
- Consumer end of the 8-tick timer: a Game of Life cell that takes the timer's 3-bit tick index and samples one neighbour per tick.
- Accumulates the live-neighbour count over ticks 0-7, then applies the birth/survival rule at the tick-7 boundary.
- Checks that the incoming tick sequence is contiguous and resynchronises on tick 0 after any break.
- Instantiated once per grid cell; all cells share one timer.

Parameters:
- INIT_ALIVE, 1'b0, cell state loaded on reset.
- BIRTH_COUNT, 4'd3, neighbour count that turns a dead cell alive.
- SURVIVE_MIN, 4'd2, lowest count at which a live cell survives.
- SURVIVE_MAX, 4'd3, highest count at which a live cell survives.

Ports:
- clk  input  1  rising-edge clock, shared with the timer.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ena  input  1  run enable.
- tick_in  input  3  tick index from the timer, 0-7.
- neighbors  input  8  neighbour alive bits; bit k is sampled on tick k.
- load  input  1  force cell state.
- load_value  input  1  state written when load=1.
- alive  output  1  current cell state.
- count_out  output  4  neighbour count of the last completed generation.
- gen_done  output  1  one-cycle pulse when a generation is applied.
- sync_err  output  1  sticky flag: tick discontinuity detected.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - alive=INIT_ALIVE, count_out=0, gen_done=0, sync_err=0.
  - acc=0, expected tick=0, FSM=S_WAIT_SYNC.
- FSM states are S_WAIT_SYNC and S_ACCUM. The accumulator acc is 4 bits, range 0-8, and cannot overflow.
- S_WAIT_SYNC:
  - If ena=1 and tick_in==0: acc<=neighbors[0], expected<=1, go to S_ACCUM.
  - Otherwise hold, with acc=0.
- S_ACCUM, when ena=1 and tick_in==expected:
  - For tick_in<7: acc<=acc+neighbors[tick_in], expected<=expected+1.
  - For tick_in==7:
    - The final count is acc+neighbors[7].
    - count_out<=final count.
    - alive<=rule(alive, final count).
    - gen_done<=1 for exactly one cycle.
    - acc<=0, expected<=0, FSM stays in S_ACCUM.
- rule(alive, n):
  - A dead cell becomes alive iff n==BIRTH_COUNT.
  - A live cell stays alive iff SURVIVE_MIN<=n<=SURVIVE_MAX.
  - In all other cases the result is 0.
- Tick mismatch in S_ACCUM (ena=1, tick_in!=expected):
  - sync_err<=1 (sticky until reset).
  - acc<=0, go to S_WAIT_SYNC.
  - alive is unchanged.
  - No same-cycle restart, even if tick_in==0; accumulation resumes at the next tick 0.
- ena=0:
  - alive and count_out hold.
  - acc clears and FSM goes to S_WAIT_SYNC on the next edge.
  - sync_err is not set.
  - The partial generation is discarded.
- load=1: alive<=load_value on the next edge.
  - Overrides a same-cycle rule update, but gen_done and count_out still update as normal.
  - Accumulation is unaffected.
- Latency: alive and gen_done change on the clock edge that samples tick 7. The new state is visible in the cycle where tick_in wraps to 0.
- Reset mid-generation: the partial count is lost and the cell waits for tick 0.

Optional Feature:
- Macro: LIFE_CELL_HISTORY_EN.
- When defined, two extra outputs are added:
  - prev_alive (1 bit): state before the last applied generation, reset to INIT_ALIVE.
  - stable (1 bit): set to 1 on gen_done when the new state equals prev_alive; reset to 0.
  - Both update only on generation edges. A load alone updates neither.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Decomposition:
- Package life_pkg:
  - TICK_W=3, N_NEIGHBORS=8, COUNT_W=4.
  - typedef logic [TICK_W-1:0] tick_t.
  - typedef logic [COUNT_W-1:0] count_t.
  - enum cell_fsm_t {S_WAIT_SYNC, S_ACCUM}.
- One combinational sub-module, life_rule: inputs alive and count, plus the rule parameters; output next_alive.

Test Plan:
- Reset with INIT_ALIVE=0; ticks 0-7 with neighbors=8'b0000_0111 -> gen_done pulses on the tick-7 edge; count_out=3; alive=1 on the tick-0 cycle that follows.
- alive=1, neighbors=8'b1111_0000 (count 4) for one full generation -> alive=0, count_out=4; repeat with count 2 -> a live cell stays 1.
- Tick sequence 0,1,2,4,... -> sync_err=1 after the tick-4 edge; no gen_done until a full 0-7 run; sync_err stays 1 until rst=0.
- ena=0 during tick 3, ena=1 again at tick 5 -> no gen_done this generation, sync_err=0; the next full generation completes normally.
- load=1, load_value=0 on the same cycle as a tick-7 birth (count=3) -> alive=0, gen_done=1, count_out=3.
- rst=0 asserted asynchronously mid-tick 4 -> outputs reset immediately; after release, accumulation starts at the next tick 0. With LIFE_CELL_HISTORY_EN, two generations at count 3 from alive=1 -> stable=1.

Source files
------------

// File: rtl/life_cell_serial_pkg.sv
// Shared widths, scalar types and FSM encoding for the serial Game of Life cell.
package life_pkg;

  localparam int TICK_W      = 3;
  localparam int N_NEIGHBORS = 8;
  localparam int COUNT_W     = 4;

  typedef logic [TICK_W-1:0]  tick_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [0:0] {
    S_WAIT_SYNC = 1'b0,
    S_ACCUM     = 1'b1
  } cell_fsm_t;

endpackage

// File: rtl/life_cell_serial_if.sv
// Timer-side inputs and cell outputs of one life cell; master drives, slave is the cell.
interface life_cell_if;
  import life_pkg::*;

  // No valid/ready pair: ena acts as the qualifier, and tick_in/neighbors/load
  // are consumed on every rising edge where ena=1 (load is honoured regardless).
  logic                   ena;
  tick_t                  tick_in;
  logic [N_NEIGHBORS-1:0] neighbors;
  logic                   load;
  logic                   load_value;
  logic                   alive;
  count_t                 count_out;
  logic                   gen_done;
  logic                   sync_err;
  cell_fsm_t              state_dbg;
`ifdef LIFE_CELL_HISTORY_EN
  logic                   prev_alive;
  logic                   stable;
`endif

  modport master (
    output ena, tick_in, neighbors, load, load_value,
    input  alive, count_out, gen_done, sync_err, state_dbg
`ifdef LIFE_CELL_HISTORY_EN
    , input prev_alive, stable
`endif
  );

  modport slave (
    input  ena, tick_in, neighbors, load, load_value,
    output alive, count_out, gen_done, sync_err, state_dbg
`ifdef LIFE_CELL_HISTORY_EN
    , output prev_alive, stable
`endif
  );

endinterface

// File: rtl/life_cell_serial_rule.sv
// Birth/survival rule: pure function of the current state and the neighbour count.
module life_rule
  import life_pkg::*;
#(
  parameter count_t BIRTH_COUNT = 4'd3,
  parameter count_t SURVIVE_MIN = 4'd2,
  parameter count_t SURVIVE_MAX = 4'd3
) (
  input  logic   alive_i,
  input  count_t count_i,
  output logic   next_alive_o
);

  always_comb begin
    next_alive_o = 1'b0;
    if (alive_i) next_alive_o = (count_i >= SURVIVE_MIN) && (count_i <= SURVIVE_MAX);
    else         next_alive_o = (count_i == BIRTH_COUNT);
  end

endmodule

// File: rtl/life_cell_serial.sv
// Serial Game of Life cell: counts one neighbour per timer tick, applies the rule at tick 7.
// Define LIFE_CELL_HISTORY_EN to add the prev_alive/stable history outputs.
module life_cell_serial
  import life_pkg::*;
#(
  parameter logic   INIT_ALIVE  = 1'b0,
  parameter count_t BIRTH_COUNT = 4'd3,
  parameter count_t SURVIVE_MIN = 4'd2,
  parameter count_t SURVIVE_MAX = 4'd3
) (
  input logic        clk,
  input logic        rst,
  life_cell_if.slave bus
);

  cell_fsm_t state_q;
  count_t    acc_q;
  tick_t     tick_exp_q;
  logic      alive_q;
  count_t    count_q;
  logic      gen_done_q;
  logic      sync_err_q;
`ifdef LIFE_CELL_HISTORY_EN
  logic      prev_alive_q;
  logic      stable_q;
`endif

  logic   nb_bit;
  count_t final_count;
  logic   rule_alive;
  logic   alive_d;

  assign nb_bit      = bus.neighbors[bus.tick_in];
  assign final_count = acc_q + {{(COUNT_W-1){1'b0}}, bus.neighbors[N_NEIGHBORS-1]};
  // A same-cycle load wins over the rule result.
  assign alive_d     = bus.load ? bus.load_value : rule_alive;

  life_rule #(
    .BIRTH_COUNT (BIRTH_COUNT),
    .SURVIVE_MIN (SURVIVE_MIN),
    .SURVIVE_MAX (SURVIVE_MAX)
  ) u_rule (
    .alive_i      (alive_q),
    .count_i      (final_count),
    .next_alive_o (rule_alive)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_WAIT_SYNC;
      acc_q        <= '0;
      tick_exp_q   <= '0;
      alive_q      <= INIT_ALIVE;
      count_q      <= '0;
      gen_done_q   <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef LIFE_CELL_HISTORY_EN
      prev_alive_q <= INIT_ALIVE;
      stable_q     <= 1'b0;
`endif
    end else begin
      gen_done_q <= 1'b0;
      case (state_q)
        S_WAIT_SYNC: begin
          acc_q      <= '0;
          tick_exp_q <= '0;
          if (bus.ena && (bus.tick_in == 3'd0)) begin
            acc_q      <= {{(COUNT_W-1){1'b0}}, bus.neighbors[0]};
            tick_exp_q <= 3'd1;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!bus.ena) begin
            acc_q      <= '0;
            tick_exp_q <= '0;
            state_q    <= S_WAIT_SYNC;
          end else if (bus.tick_in != tick_exp_q) begin
            // Resync only from the next tick 0, never in this cycle.
            sync_err_q <= 1'b1;
            acc_q      <= '0;
            tick_exp_q <= '0;
            state_q    <= S_WAIT_SYNC;
          end else if (bus.tick_in == 3'd7) begin
            count_q      <= final_count;
            alive_q      <= rule_alive;
            gen_done_q   <= 1'b1;
            acc_q        <= '0;
            tick_exp_q   <= '0;
`ifdef LIFE_CELL_HISTORY_EN
            prev_alive_q <= alive_q;
            stable_q     <= (alive_d == prev_alive_q);
`endif
          end else begin
            acc_q      <= acc_q + {{(COUNT_W-1){1'b0}}, nb_bit};
            tick_exp_q <= tick_exp_q + 3'd1;
          end
        end
        default: begin
          acc_q      <= '0;
          tick_exp_q <= '0;
          state_q    <= S_WAIT_SYNC;
        end
      endcase
      if (bus.load) alive_q <= bus.load_value;
    end
  end

  assign bus.alive     = alive_q;
  assign bus.count_out = count_q;
  assign bus.gen_done  = gen_done_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.state_dbg = state_q;
`ifdef LIFE_CELL_HISTORY_EN
  assign bus.prev_alive = prev_alive_q;
  assign bus.stable     = stable_q;
`endif

endmodule

// File: tb/tb_life_cell_serial.sv
// Directed bench for life_cell_serial: hand-computed generations, sync breaks, enable, load, reset.
module tb_life_cell_serial;
  import life_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  life_cell_if bus();

  life_cell_serial #(
    .INIT_ALIVE  (1'b0),
    .BIRTH_COUNT (4'd3),
    .SURVIVE_MIN (4'd2),
    .SURVIVE_MAX (4'd3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic step(input logic e, input tick_t t, input logic [7:0] nb,
                      input logic ld, input logic lv);
    bus.ena        = e;
    bus.tick_in    = t;
    bus.neighbors  = nb;
    bus.load       = ld;
    bus.load_value = lv;
    @(posedge clk);
    #1;
  endtask

  // Ticks 0..7 of one generation; optional load on the tick-7 cycle.
  task automatic run_gen(input logic [7:0] nb, input logic ld7, input logic lv7);
    for (int t = 0; t < 7; t++) step(1'b1, tick_t'(t), nb, 1'b0, 1'b0);
    chk("no_gen_before_t7", {7'd0, bus.gen_done}, 8'd0);
    step(1'b1, 3'd7, nb, ld7, lv7);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.ena = 1'b0; bus.tick_in = '0; bus.neighbors = '0;
    bus.load = 1'b0; bus.load_value = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alive",    {7'd0, bus.alive},     8'd0);
    chk("rst_count",    {4'd0, bus.count_out}, 8'd0);
    chk("rst_gen_done", {7'd0, bus.gen_done},  8'd0);
    chk("rst_sync_err", {7'd0, bus.sync_err},  8'd0);
    chk("rst_state",    {7'd0, bus.state_dbg}, {7'd0, S_WAIT_SYNC});
    @(negedge clk);
    rst = 1'b1;
    #1;

    // birth at count 3
    run_gen(8'b0000_0111, 1'b0, 1'b0);
    chk("birth_gen_done", {7'd0, bus.gen_done},  8'd1);
    chk("birth_count",    {4'd0, bus.count_out}, 8'd3);
    chk("birth_alive",    {7'd0, bus.alive},     8'd1);
    step(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    chk("pulse_one_cycle", {7'd0, bus.gen_done}, 8'd0);
    chk("alive_after_wrap", {7'd0, bus.alive},   8'd1);
    for (int t = 1; t < 8; t++) step(1'b1, tick_t'(t), 8'h00, 1'b0, 1'b0);
    chk("death_count0", {4'd0, bus.count_out}, 8'd0);
    chk("death_alive0", {7'd0, bus.alive},     8'd0);

    // overcrowding, regrowth, survival at 2, full house, dead stays dead at 2
    run_gen(8'b0000_0111, 1'b0, 1'b0);
    chk("regrow_alive", {7'd0, bus.alive}, 8'd1);
    run_gen(8'b1111_0000, 1'b0, 1'b0);
    chk("crowd_count", {4'd0, bus.count_out}, 8'd4);
    chk("crowd_alive", {7'd0, bus.alive},     8'd0);
    run_gen(8'b0000_0111, 1'b0, 1'b0);
    run_gen(8'b1000_0001, 1'b0, 1'b0);
    chk("survive2_count", {4'd0, bus.count_out}, 8'd2);
    chk("survive2_alive", {7'd0, bus.alive},     8'd1);
    run_gen(8'hFF, 1'b0, 1'b0);
    chk("full_count", {4'd0, bus.count_out}, 8'd8);
    chk("full_alive", {7'd0, bus.alive},     8'd0);
    run_gen(8'b0010_0100, 1'b0, 1'b0);
    chk("dead2_count", {4'd0, bus.count_out}, 8'd2);
    chk("dead2_alive", {7'd0, bus.alive},     8'd0);

    // tick break 0,1,2,4
    step(1'b1, 3'd0, 8'b0000_0111, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'b0000_0111, 1'b0, 1'b0);
    step(1'b1, 3'd2, 8'b0000_0111, 1'b0, 1'b0);
    chk("pre_break_sync", {7'd0, bus.sync_err}, 8'd0);
    step(1'b1, 3'd4, 8'b0000_0111, 1'b0, 1'b0);
    chk("break_sync_err", {7'd0, bus.sync_err},  8'd1);
    chk("break_state",    {7'd0, bus.state_dbg}, {7'd0, S_WAIT_SYNC});
    for (int t = 5; t < 8; t++) begin
      step(1'b1, tick_t'(t), 8'b0000_0111, 1'b0, 1'b0);
      chk("break_no_gen", {7'd0, bus.gen_done}, 8'd0);
    end
    chk("break_alive_hold", {7'd0, bus.alive}, 8'd0);
    run_gen(8'b0000_0111, 1'b0, 1'b0);
    chk("resync_gen_done", {7'd0, bus.gen_done}, 8'd1);
    chk("resync_alive",    {7'd0, bus.alive},    8'd1);
    chk("sync_err_sticky", {7'd0, bus.sync_err}, 8'd1);

    // asynchronous reset in the middle of tick 4
    for (int t = 0; t < 4; t++) step(1'b1, tick_t'(t), 8'b0000_0111, 1'b0, 1'b0);
    bus.tick_in = 3'd4;
    #2 rst = 1'b0;
    #1;
    chk("arst_alive",    {7'd0, bus.alive},     8'd0);
    chk("arst_count",    {4'd0, bus.count_out}, 8'd0);
    chk("arst_sync_err", {7'd0, bus.sync_err},  8'd0);
    #2 rst = 1'b1;
    step(1'b1, 3'd4, 8'b0000_0111, 1'b0, 1'b0);
    for (int t = 5; t < 8; t++) step(1'b1, tick_t'(t), 8'b0000_0111, 1'b0, 1'b0);
    chk("arst_no_gen",   {7'd0, bus.gen_done}, 8'd0);
    chk("arst_no_birth", {7'd0, bus.alive},    8'd0);
    run_gen(8'b0000_0111, 1'b0, 1'b0);
    chk("arst_resume_count", {4'd0, bus.count_out}, 8'd3);
    chk("arst_resume_alive", {7'd0, bus.alive},     8'd1);

    // ena dropped for ticks 3-4 of a generation that would kill the cell
    for (int t = 0; t < 8; t++) begin
      step((t == 3 || t == 4) ? 1'b0 : 1'b1, tick_t'(t), 8'hFF, 1'b0, 1'b0);
      chk("ena_no_gen", {7'd0, bus.gen_done}, 8'd0);
    end
    chk("ena_no_sync_err", {7'd0, bus.sync_err},  8'd0);
    chk("ena_alive_hold",  {7'd0, bus.alive},     8'd1);
    chk("ena_count_hold",  {4'd0, bus.count_out}, 8'd3);
    run_gen(8'b0100_0000, 1'b0, 1'b0);
    chk("lonely_gen_done", {7'd0, bus.gen_done},  8'd1);
    chk("lonely_count",    {4'd0, bus.count_out}, 8'd1);
    chk("lonely_alive",    {7'd0, bus.alive},     8'd0);

    // load=0 on the tick-7 birth edge
    run_gen(8'b0000_0111, 1'b1, 1'b0);
    chk("load_gen_done", {7'd0, bus.gen_done},  8'd1);
    chk("load_count",    {4'd0, bus.count_out}, 8'd3);
    chk("load_alive",    {7'd0, bus.alive},     8'd0);

    // load=1 mid-generation; accumulation carries on to a count of 0
    step(1'b1, 3'd0, 8'h00, 1'b1, 1'b1);
    chk("load_mid_alive", {7'd0, bus.alive}, 8'd1);
    for (int t = 1; t < 8; t++) step(1'b1, tick_t'(t), 8'h00, 1'b0, 1'b0);
    chk("load_mid_gen",   {7'd0, bus.gen_done},  8'd1);
    chk("load_mid_count", {4'd0, bus.count_out}, 8'd0);
    chk("load_mid_die",   {7'd0, bus.alive},     8'd0);

`ifdef LIFE_CELL_HISTORY_EN
    @(negedge clk);
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("hist_rst_prev",   {7'd0, bus.prev_alive}, 8'd0);
    chk("hist_rst_stable", {7'd0, bus.stable},     8'd0);
    step(1'b1, 3'd0, 8'b0000_0111, 1'b1, 1'b1);
    chk("hist_load_prev", {7'd0, bus.prev_alive}, 8'd0);
    for (int t = 1; t < 8; t++) step(1'b1, tick_t'(t), 8'b0000_0111, 1'b0, 1'b0);
    chk("hist_g1_prev",   {7'd0, bus.prev_alive}, 8'd1);
    chk("hist_g1_stable", {7'd0, bus.stable},     8'd0);
    run_gen(8'b0000_0111, 1'b0, 1'b0);
    chk("hist_g2_prev",   {7'd0, bus.prev_alive}, 8'd1);
    chk("hist_g2_stable", {7'd0, bus.stable},     8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
